// File: rtl/d16_bus_pkg.sv
// ---------------------------------------------------------------------------
// d16_bus_pkg
//   Shared definitions for the d16 SoC bus: transfer FSM states, decode
//   targets and the default address map. Software headers mirror the address
//   map constants below.
// ---------------------------------------------------------------------------
package d16_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } bus_state_e;

  typedef enum logic [1:0] {
    TGT_MEM  = 2'd0,
    TGT_UART = 2'd1,
    TGT_NONE = 2'd2
  } bus_target_e;

  // Default address map: blkmem at 0 .. 2**MEM_AW-1, uart registers at
  // UART_BASE .. UART_BASE + 2**UART_AW - 1, everything else unmapped.
  localparam int          D16_MEM_AW    = 12;
  localparam logic [15:0] D16_UART_BASE = 16'hFF00;
  localparam int          D16_UART_AW   = 2;

endpackage

// File: rtl/bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter
//   Two-requester round-robin arbiter. On a tie the requester that was not
//   granted last wins. last_grant only moves when arb_en is high and someone
//   is requesting, so between arbitration points it names the current owner.
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset (last_grant -> requester 1)
//   req[1:0]    request per requester
//   arb_en      arbitration point; commits grant into last_grant
//   grant[1:0]  one-hot combinational grant for the current req
//   last_grant  one-hot registered owner of the most recent grant
// ---------------------------------------------------------------------------
module bus_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       arb_en,
  output logic [1:0] grant,
  output logic [1:0] last_grant
);

  // NOTE: every combinational output gets a default first so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant[0] ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Requester 1 counts as last granted, so requester 0 wins the first tie.
      last_grant <= 2'b10;
    end else if (arb_en && (|req)) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/bus_ctrl.sv
// ---------------------------------------------------------------------------
// bus_ctrl
//   Two-master, two-slave bus controller for the d16 SoC. m0 (CPU) and m1
//   (loader/debug) are arbitrated round-robin; the winner's request is latched
//   and decoded to blkmem, uart or unmapped. The slaves have no handshake, so
//   this block owns all timing:
//     IDLE  -> arbitrate, latch addr/we/dat, decode
//     ISSUE -> one-cycle strobe to the decoded slave (none if unmapped)
//     WAIT  -> capture slave read data (0 for writes and unmapped)
//     ACK   -> one-cycle ack (or err if unmapped) to the owner
//   A request seen in IDLE at cycle 0 is strobed at cycle 1 and acked at 3.
//   If the owner drops cyc during ISSUE/WAIT the access still completes but
//   the ack/err pulse and the read-data update are suppressed.
//
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_mX_cyc/we/addr/dat           master X request (held until ack/err)
//   o_mX_dat/ack/err               master X read data, done and error pulses
//   o_mem_cyc, o_uart_cyc          one-cycle slave strobes
//   o_s_addr, o_s_we, o_s_dat      latched request driven to the slaves
//   i_mem_dat, i_uart_dat          slave read data, valid one cycle after strobe
//   o_grant                        one-hot current owner, 0 when idle (debug)
// ---------------------------------------------------------------------------
module bus_ctrl
  import d16_bus_pkg::*;
#(
  parameter int             DW        = 16,
  parameter int             AW        = 16,
  parameter int             MEM_AW    = D16_MEM_AW,
  parameter logic [AW-1:0]  UART_BASE = AW'(D16_UART_BASE),
  parameter int             UART_AW   = D16_UART_AW
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_m0_cyc,
  input  logic          i_m0_we,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [DW-1:0] i_m0_dat,
  output logic [DW-1:0] o_m0_dat,
  output logic          o_m0_ack,
  output logic          o_m0_err,
  input  logic          i_m1_cyc,
  input  logic          i_m1_we,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m1_dat,
  output logic [DW-1:0] o_m1_dat,
  output logic          o_m1_ack,
  output logic          o_m1_err,
  output logic          o_mem_cyc,
  output logic          o_uart_cyc,
  output logic [AW-1:0] o_s_addr,
  output logic          o_s_we,
  output logic [DW-1:0] o_s_dat,
  input  logic [DW-1:0] i_mem_dat,
  input  logic [DW-1:0] i_uart_dat,
  output logic [1:0]    o_grant
);

  // Address map bounds, one bit wider than the address so the end of a
  // region that touches the top of the address space still compares.
  localparam logic [AW:0] MEM_END  = (AW+1)'(1) << MEM_AW;
  localparam logic [AW:0] UART_LO  = {1'b0, UART_BASE};
  localparam logic [AW:0] UART_HI  = UART_LO + ((AW+1)'(1) << UART_AW);

  bus_state_e    state, state_next;
  bus_target_e   target, sel_target;
  logic          aborted;

  logic [1:0]    req;
  logic [1:0]    arb_grant;
  logic [1:0]    owner;
  logic          owner_cyc;
  logic          drop;

  logic [AW-1:0] sel_addr;
  logic          sel_we;
  logic [DW-1:0] sel_dat;
  logic [DW-1:0] rd_data;

  assign req = {i_m1_cyc, i_m0_cyc};

  // Outside IDLE the arbiter's registered last grant is the transfer owner.
  bus_rr_arbiter u_arb (
    .clk        (i_clk),
    .reset      (i_reset),
    .req        (req),
    .arb_en     (state == ST_IDLE),
    .grant      (arb_grant),
    .last_grant (owner)
  );

  // Request of the master being granted this cycle, and its decode.
  always_comb begin
    sel_addr   = arb_grant[1] ? i_m1_addr : i_m0_addr;
    sel_we     = arb_grant[1] ? i_m1_we   : i_m0_we;
    sel_dat    = arb_grant[1] ? i_m1_dat  : i_m0_dat;
    sel_target = TGT_NONE;
    if ({1'b0, sel_addr} < MEM_END) begin
      sel_target = TGT_MEM;
    end else if (({1'b0, sel_addr} >= UART_LO) && ({1'b0, sel_addr} < UART_HI)) begin
      sel_target = TGT_UART;
    end
  end

  // The owner abandoning its request mid-transfer cancels only the response.
  assign owner_cyc = |(owner & req);
  assign drop      = ((state == ST_ISSUE) || (state == ST_WAIT)) && !owner_cyc;

  always_comb begin
    rd_data = '0;
    if (!o_s_we) begin
      case (target)
        TGT_MEM:  rd_data = i_mem_dat;
        TGT_UART: rd_data = i_uart_dat;
        default:  rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    o_mem_cyc  = 1'b0;
    o_uart_cyc = 1'b0;
    o_m0_ack   = 1'b0;
    o_m1_ack   = 1'b0;
    o_m0_err   = 1'b0;
    o_m1_err   = 1'b0;
    o_grant    = 2'b00;
    case (state)
      ST_IDLE: begin
        if (|req) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_next = ST_WAIT;
        o_grant    = owner;
        o_mem_cyc  = (target == TGT_MEM);
        o_uart_cyc = (target == TGT_UART);
      end
      ST_WAIT: begin
        state_next = ST_ACK;
        o_grant    = owner;
      end
      ST_ACK: begin
        state_next = ST_IDLE;
        o_grant    = owner;
        if (!aborted) begin
          if (target == TGT_NONE) begin
            o_m0_err = owner[0];
            o_m1_err = owner[1];
          end else begin
            o_m0_ack = owner[0];
            o_m1_ack = owner[1];
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath registers. o_mX_dat is loaded at the end of WAIT so it is valid
  // alongside the ack and then held until that master's next completion.
  // NOTE: the datapath registers are reset as well as the FSM because they
  // drive ports that must read 0 out of reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_s_addr <= '0;
      o_s_we   <= 1'b0;
      o_s_dat  <= '0;
      target   <= TGT_NONE;
      aborted  <= 1'b0;
      o_m0_dat <= '0;
      o_m1_dat <= '0;
    end else begin
      if ((state == ST_IDLE) && (|req)) begin
        o_s_addr <= sel_addr;
        o_s_we   <= sel_we;
        o_s_dat  <= sel_dat;
        target   <= sel_target;
        aborted  <= 1'b0;
      end
      if (drop) aborted <= 1'b1;
      if ((state == ST_WAIT) && !aborted && owner_cyc) begin
        if (owner[0]) o_m0_dat <= rd_data;
        else          o_m1_dat <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bus_ctrl
//   Self-checking bench for bus_ctrl. Expected responses (master, ack/err,
//   data, cycle) are queued when a request is driven and checked by a monitor
//   when the DUT pulses ack/err. Simple blkmem/uart slave models answer
//   strobes one cycle later. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_bus_ctrl;

  logic        i_clk, i_reset;
  logic        i_m0_cyc, i_m0_we, i_m1_cyc, i_m1_we;
  logic [15:0] i_m0_addr, i_m0_dat, i_m1_addr, i_m1_dat;
  logic [15:0] o_m0_dat, o_m1_dat;
  logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
  logic        o_mem_cyc, o_uart_cyc, o_s_we;
  logic [15:0] o_s_addr, o_s_dat, i_mem_dat, i_uart_dat;
  logic [1:0]  o_grant;

  bus_ctrl dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_m0_cyc   (i_m0_cyc),
    .i_m0_we    (i_m0_we),
    .i_m0_addr  (i_m0_addr),
    .i_m0_dat   (i_m0_dat),
    .o_m0_dat   (o_m0_dat),
    .o_m0_ack   (o_m0_ack),
    .o_m0_err   (o_m0_err),
    .i_m1_cyc   (i_m1_cyc),
    .i_m1_we    (i_m1_we),
    .i_m1_addr  (i_m1_addr),
    .i_m1_dat   (i_m1_dat),
    .o_m1_dat   (o_m1_dat),
    .o_m1_ack   (o_m1_ack),
    .o_m1_err   (o_m1_err),
    .o_mem_cyc  (o_mem_cyc),
    .o_uart_cyc (o_uart_cyc),
    .o_s_addr   (o_s_addr),
    .o_s_we     (o_s_we),
    .o_s_dat    (o_s_dat),
    .i_mem_dat  (i_mem_dat),
    .i_uart_dat (i_uart_dat),
    .o_grant    (o_grant)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int cyc_cnt = 0;
  always @(posedge i_clk) cyc_cnt++;

  int n_checks = 0;
  int n_errors = 0;

  typedef enum {T_MEM, T_UART, T_NONE} tgt_t;
  typedef struct {
    int          master;
    bit          is_err;
    logic [15:0] data;
    int          cycle;
  } exp_t;
  exp_t exp_q[$];

  // Reference address map.
  function automatic tgt_t exp_target(input logic [15:0] a);
    if (a < 16'h1000)                       return T_MEM;
    else if (a >= 16'hFF00 && a <= 16'hFF03) return T_UART;
    else                                    return T_NONE;
  endfunction

  // ---------------- slave models ----------------
  logic [15:0] mem_model [4096];
  logic [15:0] uart_model [4];
  int          mem_cnt = 0, uart_cnt = 0, mem_last = -1, uart_last = -1;
  bit          mem_pend = 0, uart_pend = 0;
  logic [11:0] mem_a;
  logic [1:0]  uart_a;

  // Read data is presented only in the cycle after the strobe, junk otherwise.
  always @(negedge i_clk) begin
    i_mem_dat  = mem_pend  ? mem_model[mem_a]   : 16'hDEAD;
    i_uart_dat = uart_pend ? uart_model[uart_a] : 16'hDEAD;
    mem_pend  = 0;
    uart_pend = 0;
    if (o_mem_cyc === 1'b1) begin
      mem_cnt++;
      mem_last = cyc_cnt;
      if (o_s_we) mem_model[o_s_addr[11:0]] = o_s_dat;
      else begin mem_pend = 1; mem_a = o_s_addr[11:0]; end
    end
    if (o_uart_cyc === 1'b1) begin
      uart_cnt++;
      uart_last = cyc_cnt;
      if (o_s_we) uart_model[o_s_addr[1:0]] = o_s_dat;
      else begin uart_pend = 1; uart_a = o_s_addr[1:0]; end
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge i_clk) begin
    logic [1:0]  ack, err;
    logic [15:0] dat;
    exp_t        e;
    ack = {o_m1_ack, o_m0_ack};
    err = {o_m1_err, o_m0_err};
    for (int m = 0; m < 2; m++) begin
      if (ack[m] === 1'b1 || err[m] === 1'b1) begin
        dat = (m == 0) ? o_m0_dat : o_m1_dat;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_resp: m%0d ack=%b err=%b cycle=%0d, none expected",
                   m, ack[m], err[m], cyc_cnt);
        end else begin
          e = exp_q.pop_front();
          if (e.master != m || e.is_err !== err[m] || ack[m] === err[m] ||
              dat !== e.data || cyc_cnt != e.cycle) begin
            n_errors++;
            $display("FAIL response: got m%0d ack=%b err=%b dat=%h cycle=%0d, want m%0d err=%0d dat=%h cycle=%0d",
                     m, ack[m], err[m], dat, cyc_cnt, e.master, e.is_err, e.data, e.cycle);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [15:0] obs_addr, obs_dat;
  logic        obs_we;

  task automatic set_master(input int m, input logic cyc, input logic we,
                            input logic [15:0] addr, input logic [15:0] dat);
    if (m == 0) begin i_m0_cyc = cyc; i_m0_we = we; i_m0_addr = addr; i_m0_dat = dat; end
    else        begin i_m1_cyc = cyc; i_m1_we = we; i_m1_addr = addr; i_m1_dat = dat; end
  endtask

  // One complete transfer from IDLE; the master's inputs are scrambled after
  // the grant to show that the latched copy is used. Returns one cycle after ACK.
  task automatic drive_xfer(input int m, input logic [15:0] addr, input logic we,
                            input logic [15:0] dat);
    exp_t e;
    tgt_t t;
    t = exp_target(addr);
    e.master = m;
    e.cycle  = cyc_cnt + 3;
    e.is_err = (t == T_NONE);
    if (we || t == T_NONE) e.data = 16'h0000;
    else if (t == T_MEM)   e.data = mem_model[addr[11:0]];
    else                   e.data = uart_model[addr[1:0]];
    exp_q.push_back(e);
    set_master(m, 1'b1, we, addr, dat);
    @(negedge i_clk);
    set_master(m, 1'b1, ~we, ~addr, ~dat);
    @(negedge i_clk);
    obs_addr = o_s_addr;
    obs_we   = o_s_we;
    obs_dat  = o_s_dat;
    @(negedge i_clk);
    set_master(m, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge i_clk);
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drained: %0d responses still pending, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_reset = 1'b1;
    set_master(0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_master(1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(negedge i_clk);
    n_checks += 5;
    if (o_grant !== 2'b00) begin n_errors++; $display("FAIL reset_grant: got %b want 00", o_grant); end
    if ({o_mem_cyc, o_uart_cyc} !== 2'b00) begin n_errors++;
      $display("FAIL reset_strobes: got mem=%b uart=%b want 0", o_mem_cyc, o_uart_cyc); end
    if ({o_m0_ack, o_m0_err, o_m1_ack, o_m1_err} !== 4'b0000) begin n_errors++;
      $display("FAIL reset_resp: got %b want 0000", {o_m0_ack, o_m0_err, o_m1_ack, o_m1_err}); end
    if ({o_s_addr, o_s_we, o_s_dat} !== 33'h0) begin n_errors++;
      $display("FAIL reset_sbus: got addr=%h we=%b dat=%h want 0", o_s_addr, o_s_we, o_s_dat); end
    if ({o_m0_dat, o_m1_dat} !== 32'h0) begin n_errors++;
      $display("FAIL reset_mdat: got %h/%h want 0", o_m0_dat, o_m1_dat); end
    i_reset = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_mem_read();
    int c_mem, c_uart, t0;
    c_mem = mem_cnt; c_uart = uart_cnt; t0 = cyc_cnt;
    drive_xfer(0, 16'h0010, 1'b0, 16'h0);
    n_checks += 3;
    if (mem_cnt != c_mem + 1 || mem_last != t0 + 1) begin n_errors++;
      $display("FAIL mem_read_strobe: got count=%0d at cycle %0d want 1 at %0d", mem_cnt - c_mem, mem_last, t0 + 1); end
    if (uart_cnt != c_uart) begin n_errors++;
      $display("FAIL mem_read_uart: got %0d uart strobes want 0", uart_cnt - c_uart); end
    if (o_m0_dat !== 16'hBEEF) begin n_errors++;
      $display("FAIL mem_read_data: got %h want beef", o_m0_dat); end
    check_drained("mem_read");
  endtask

  task automatic test_uart_write();
    int c_mem, c_uart, t0;
    c_mem = mem_cnt; c_uart = uart_cnt; t0 = cyc_cnt;
    drive_xfer(1, 16'hFF01, 1'b1, 16'h0041);
    n_checks += 4;
    if (uart_cnt != c_uart + 1 || uart_last != t0 + 1) begin n_errors++;
      $display("FAIL uart_write_strobe: got count=%0d at cycle %0d want 1 at %0d", uart_cnt - c_uart, uart_last, t0 + 1); end
    if (mem_cnt != c_mem) begin n_errors++;
      $display("FAIL uart_write_mem: got %0d mem strobes want 0", mem_cnt - c_mem); end
    if ({obs_addr, obs_we, obs_dat} !== {16'hFF01, 1'b1, 16'h0041}) begin n_errors++;
      $display("FAIL uart_write_sbus: got addr=%h we=%b dat=%h want ff01 1 0041", obs_addr, obs_we, obs_dat); end
    if (uart_model[1] !== 16'h0041) begin n_errors++;
      $display("FAIL uart_write_reg: got %h want 0041", uart_model[1]); end
    check_drained("uart_write");
  endtask

  task automatic test_round_robin();
    int   t0;
    logic [1:0] exp_g;
    exp_t e;
    i_reset = 1'b1;
    @(negedge i_clk);
    set_master(0, 1'b1, 1'b0, 16'h0020, 16'h0);
    set_master(1, 1'b1, 1'b0, 16'h0030, 16'h0);
    i_reset = 1'b0;
    t0 = cyc_cnt;
    for (int x = 0; x < 4; x++) begin
      e.master = x % 2;
      e.is_err = 1'b0;
      e.data   = (x % 2 == 0) ? mem_model[12'h020] : mem_model[12'h030];
      e.cycle  = t0 + 3 + 4 * x;
      exp_q.push_back(e);
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge i_clk);
      if ((k - 1) % 4 == 3)              exp_g = 2'b00;
      else if (((k - 1) / 4) % 2 == 0)   exp_g = 2'b01;
      else                               exp_g = 2'b10;
      n_checks++;
      if (o_grant !== exp_g) begin n_errors++;
        $display("FAIL rr_grant: cycle %0d got %b want %b", k, o_grant, exp_g); end
      if (k == 15) begin
        set_master(0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_master(1, 1'b0, 1'b0, 16'h0, 16'h0);
      end
    end
    check_drained("round_robin");
  endtask

  task automatic test_decode();
    logic [15:0] addrs [7] = '{16'h0FFF, 16'h1000, 16'h8000, 16'hFEFF, 16'hFF00, 16'hFF03, 16'hFF04};
    tgt_t        tgts  [7] = '{T_MEM, T_NONE, T_NONE, T_NONE, T_UART, T_UART, T_NONE};
    int c_mem, c_uart;
    for (int i = 0; i < 7; i++) begin
      c_mem = mem_cnt; c_uart = uart_cnt;
      drive_xfer(i % 2, addrs[i], 1'b0, 16'h0);
      n_checks++;
      if ((mem_cnt - c_mem) != int'(tgts[i] == T_MEM) || (uart_cnt - c_uart) != int'(tgts[i] == T_UART)) begin
        n_errors++;
        $display("FAIL decode_%h: got mem=%0d uart=%0d strobes want %s", addrs[i],
                 mem_cnt - c_mem, uart_cnt - c_uart, tgts[i].name());
      end
    end
    check_drained("decode");
  endtask

  task automatic test_reset_mid();
    int t1, c_mem;
    exp_t e;
    c_mem = mem_cnt;
    set_master(0, 1'b1, 1'b0, 16'h0040, 16'h0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    n_checks += 3;
    if ({o_grant, o_mem_cyc, o_uart_cyc, o_m0_ack, o_m0_err, o_m1_ack, o_m1_err} !== 8'h0) begin
      n_errors++;
      $display("FAIL reset_mid_ctrl: got grant=%b strobes=%b%b resp=%b%b%b%b want 0", o_grant,
               o_mem_cyc, o_uart_cyc, o_m0_ack, o_m0_err, o_m1_ack, o_m1_err);
    end
    if ({o_s_addr, o_s_we, o_s_dat} !== 33'h0) begin n_errors++;
      $display("FAIL reset_mid_sbus: got addr=%h we=%b dat=%h want 0", o_s_addr, o_s_we, o_s_dat); end
    if ({o_m0_dat, o_m1_dat} !== 32'h0) begin n_errors++;
      $display("FAIL reset_mid_mdat: got %h/%h want 0", o_m0_dat, o_m1_dat); end
    i_reset = 1'b0;
    t1 = cyc_cnt;
    e.master = 0; e.is_err = 1'b0; e.data = mem_model[12'h040]; e.cycle = t1 + 3;
    exp_q.push_back(e);
    repeat (3) @(negedge i_clk);
    set_master(0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge i_clk);
    n_checks++;
    if (mem_cnt != c_mem + 2) begin n_errors++;
      $display("FAIL reset_mid_strobes: got %0d mem strobes want 2", mem_cnt - c_mem); end
    check_drained("reset_mid");
  endtask

  task automatic test_drop_cyc();
    int t0, c_mem;
    exp_t e;
    c_mem = mem_cnt; t0 = cyc_cnt;
    set_master(0, 1'b1, 1'b0, 16'h0050, 16'h0);
    @(negedge i_clk);
    set_master(1, 1'b1, 1'b0, 16'h0060, 16'h0);
    e.master = 1; e.is_err = 1'b0; e.data = mem_model[12'h060]; e.cycle = t0 + 7;
    exp_q.push_back(e);
    @(negedge i_clk);
    set_master(0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int k = 3; k <= 7; k++) begin
      @(negedge i_clk);
      if (k == 7) set_master(1, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    @(negedge i_clk);
    n_checks += 3;
    if (mem_cnt != c_mem + 2 || mem_last != t0 + 5) begin n_errors++;
      $display("FAIL drop_strobes: got %0d strobes last at %0d want 2 last at %0d", mem_cnt - c_mem, mem_last, t0 + 5); end
    if (o_m0_dat !== mem_model[12'h040]) begin n_errors++;
      $display("FAIL drop_m0_dat: got %h want held %h", o_m0_dat, mem_model[12'h040]); end
    if (o_grant !== 2'b00) begin n_errors++;
      $display("FAIL drop_idle_grant: got %b want 00", o_grant); end
    check_drained("drop_cyc");
  endtask

  task automatic test_back_to_back();
    drive_xfer(0, 16'h0123, 1'b1, 16'h1234);
    drive_xfer(1, 16'h0123, 1'b0, 16'h0);
    n_checks++;
    if (o_m1_dat !== 16'h1234) begin n_errors++;
      $display("FAIL readback: got %h want 1234", o_m1_dat); end
    check_drained("back_to_back");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem_model[i] = 16'(i) ^ 16'h5A5A;
    mem_model[16] = 16'hBEEF;
    for (int i = 0; i < 4; i++) uart_model[i] = 16'h1100 + 16'(i);
    i_mem_dat  = 16'hDEAD;
    i_uart_dat = 16'hDEAD;
    test_reset();
    test_mem_read();
    test_uart_write();
    test_round_robin();
    test_decode();
    test_reset_mid();
    test_drop_cyc();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
